// File: rtl/cfi_shadow_stack_stage.sv
// cfi_shadow_stack_stage
//   Control-flow integrity stage on the core commit ports. Committed calls and
//   returns inside [FILTER_LO, FILTER_HI) are queued (several per cycle), then
//   drained one per cycle into a hardware shadow stack. A return whose target
//   differs from the stacked link address, a stack underflow/overflow, or a
//   queue overrun latches a sticky fault that only fault_clear_i releases.
//
// Ports
//   clk_i, rst_i         clock, synchronous active-high reset
//   en_i                 CFI enable (gates qualification and throttling)
//   commit_*_i           per-port valid/ack/kind/pc/addr of retiring instructions
//   fault_clear_i        clears fault and flushes queue + shadow stack
//   cfi_wait_o           commit must not ack (queue cannot take a full group, or fault)
//   cfi_fault_o          sticky fault flag
//   fault_cause_o        0 none, 1 mismatch, 2 underflow, 3 SS overflow, 4 overrun
//   fault_pc_o           pc of the faulting event
//   queue_usage_o        occupied queue entries
//   ss_depth_o           occupied shadow stack entries

// Per-port qualifier: is this commit slot a monitored call/return?
module cfi_qual_lane #(
    parameter int              XLEN      = 64,
    parameter logic [XLEN-1:0] FILTER_LO = 'h8000_0000,
    parameter logic [XLEN-1:0] FILTER_HI = '1
) (
    input  logic            en_i,
    input  logic            valid_i,
    input  logic            ack_i,
    input  logic [1:0]      kind_i,
    input  logic [XLEN-1:0] pc_i,
    output logic            qual_o
);
    assign qual_o = en_i && valid_i && ack_i &&
                    (kind_i == 2'd1 || kind_i == 2'd2) &&
                    (pc_i >= FILTER_LO) && (pc_i < FILTER_HI);
endmodule

module cfi_shadow_stack_stage #(
    parameter int              NR_COMMIT_PORTS  = 2,
    parameter int              NR_QUEUE_ENTRIES = 8,
    parameter int              SS_DEPTH         = 16,
    parameter int              XLEN             = 64,
    parameter logic [XLEN-1:0] FILTER_LO        = 'h8000_0000,
    parameter logic [XLEN-1:0] FILTER_HI        = '1
) (
    input  logic                                      clk_i,
    input  logic                                      rst_i,
    input  logic                                      en_i,
    input  logic [NR_COMMIT_PORTS-1:0]                commit_valid_i,
    input  logic [NR_COMMIT_PORTS-1:0]                commit_ack_i,
    input  logic [NR_COMMIT_PORTS-1:0][1:0]           commit_kind_i,
    input  logic [NR_COMMIT_PORTS-1:0][XLEN-1:0]      commit_pc_i,
    input  logic [NR_COMMIT_PORTS-1:0][XLEN-1:0]      commit_addr_i,
    input  logic                                      fault_clear_i,
    output logic                                      cfi_wait_o,
    output logic                                      cfi_fault_o,
    output logic [2:0]                                fault_cause_o,
    output logic [XLEN-1:0]                           fault_pc_o,
    output logic [$clog2(NR_QUEUE_ENTRIES+1)-1:0]     queue_usage_o,
    output logic [$clog2(SS_DEPTH+1)-1:0]             ss_depth_o
);
    localparam int PTR_W = (NR_QUEUE_ENTRIES > 1) ? $clog2(NR_QUEUE_ENTRIES) : 1;
    localparam int USE_W = $clog2(NR_QUEUE_ENTRIES+1);
    localparam int SP_W  = $clog2(SS_DEPTH+1);

    // ---------------- state ----------------
    logic [1:0]       q_kind [NR_QUEUE_ENTRIES];
    logic [XLEN-1:0]  q_pc   [NR_QUEUE_ENTRIES];
    logic [XLEN-1:0]  q_addr [NR_QUEUE_ENTRIES];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [USE_W-1:0] usage;
    logic [XLEN-1:0]  ss_mem [SS_DEPTH];
    logic [SP_W-1:0]  sp;
    logic             fault_q;
    logic [2:0]       cause_q;
    logic [XLEN-1:0]  fpc_q;

    // ---------------- qualification ----------------
    logic [NR_COMMIT_PORTS-1:0] qual;

    for (genvar g = 0; g < NR_COMMIT_PORTS; g++) begin : g_lane
        cfi_qual_lane #(
            .XLEN      (XLEN),
            .FILTER_LO (FILTER_LO),
            .FILTER_HI (FILTER_HI)
        ) u_lane (
            .en_i    (en_i),
            .valid_i (commit_valid_i[g]),
            .ack_i   (commit_ack_i[g]),
            .kind_i  (commit_kind_i[g]),
            .pc_i    (commit_pc_i[g]),
            .qual_o  (qual[g])
        );
    end

    // ---------------- push side ----------------
    // Each qualified port gets a rank (number of qualified lower ports); ranks
    // below the free count are stored, the rank equal to it is the first drop.
    // Free space is taken from registered usage, so a same-cycle pop does not help.
    int               free_cnt;
    int               n_push;
    logic [NR_COMMIT_PORTS-1:0] store;
    logic [PTR_W-1:0] slot [NR_COMMIT_PORTS];
    logic             drop_any;
    logic [XLEN-1:0]  drop_pc;

    always_comb begin
        int cnt;
        cnt      = 0;
        free_cnt = NR_QUEUE_ENTRIES - int'(usage);
        n_push   = 0;
        drop_any = 1'b0;
        drop_pc  = '0;
        for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
            store[i] = 1'b0;
            slot[i]  = PTR_W'((int'(wr_ptr) + cnt) % NR_QUEUE_ENTRIES);
            if (qual[i]) begin
                if (cnt < free_cnt) begin
                    store[i] = 1'b1;
                    n_push   = n_push + 1;
                end else if (cnt == free_cnt) begin
                    drop_any = 1'b1;
                    drop_pc  = commit_pc_i[i];
                end
                cnt = cnt + 1;
            end
        end
    end

    // ---------------- backend ----------------
    logic            pop;
    logic [1:0]      h_kind;
    logic [XLEN-1:0] h_pc, h_addr;
    logic [SP_W-1:0] top_idx;
    logic            ss_push, ss_pop, be_fault;
    logic [2:0]      be_cause;

    assign pop     = (usage != '0) && !fault_q;
    assign h_kind  = q_kind[rd_ptr];
    assign h_pc    = q_pc[rd_ptr];
    assign h_addr  = q_addr[rd_ptr];
    assign top_idx = (sp != '0) ? sp - 1'b1 : '0;

    always_comb begin
        ss_push  = 1'b0;
        ss_pop   = 1'b0;
        be_fault = 1'b0;
        be_cause = 3'd0;
        if (pop) begin
            if (h_kind == 2'd1) begin
                if (int'(sp) < SS_DEPTH) ss_push = 1'b1;
                else begin
                    be_fault = 1'b1;
                    be_cause = 3'd3;
                end
            end else begin
                if (sp == '0) begin
                    be_fault = 1'b1;
                    be_cause = 3'd2;
                end else begin
                    // Pop even on mismatch: the faulting entry is consumed.
                    ss_pop = 1'b1;
                    if (ss_mem[top_idx] != h_addr) begin
                        be_fault = 1'b1;
                        be_cause = 3'd1;
                    end
                end
            end
        end
    end

    // ---------------- sequential ----------------
    always_ff @(posedge clk_i) begin
        if (rst_i || fault_clear_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            usage   <= '0;
            sp      <= '0;
            fault_q <= 1'b0;
            cause_q <= 3'd0;
            fpc_q   <= '0;
        end else begin
            for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
                if (store[i]) begin
                    q_kind[slot[i]] <= commit_kind_i[i];
                    q_pc[slot[i]]   <= commit_pc_i[i];
                    q_addr[slot[i]] <= commit_addr_i[i];
                end
            end
            wr_ptr <= PTR_W'((int'(wr_ptr) + n_push) % NR_QUEUE_ENTRIES);
            if (pop) rd_ptr <= PTR_W'((int'(rd_ptr) + 1) % NR_QUEUE_ENTRIES);
            usage <= USE_W'(int'(usage) + n_push - (pop ? 1 : 0));

            if (ss_push) begin
                ss_mem[sp[SP_W-1:0]] <= h_addr;
                sp                   <= sp + 1'b1;
            end else if (ss_pop) begin
                sp <= sp - 1'b1;
            end

            // The backend event is older than any same-cycle overrun, so it wins.
            if (!fault_q) begin
                if (be_fault) begin
                    fault_q <= 1'b1;
                    cause_q <= be_cause;
                    fpc_q   <= h_pc;
                end else if (drop_any) begin
                    fault_q <= 1'b1;
                    cause_q <= 3'd4;
                    fpc_q   <= drop_pc;
                end
            end
        end
    end

    // ---------------- outputs ----------------
    assign cfi_wait_o    = (en_i && ((NR_QUEUE_ENTRIES - int'(usage)) < NR_COMMIT_PORTS)) || fault_q;
    assign cfi_fault_o   = fault_q;
    assign fault_cause_o = cause_q;
    assign fault_pc_o    = fpc_q;
    assign queue_usage_o = usage;
    assign ss_depth_o    = sp;

endmodule

// File: tb/tb_cfi_shadow_stack_stage.sv
// Directed bench for cfi_shadow_stack_stage with default parameters
// (2 ports, 8 queue entries, 16 shadow stack entries, 64-bit addresses).
module tb_cfi_shadow_stack_stage;
    localparam int P = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic [P-1:0]      valid, ack;
    logic [P-1:0][1:0] kind;
    logic [P-1:0][63:0] pc, addr;
    logic              fclr;
    logic              wait_o, fault_o;
    logic [2:0]        cause_o;
    logic [63:0]       fpc_o;
    logic [3:0]        usage_o;
    logic [4:0]        ssd_o;

    int n_checks = 0;
    int n_errors = 0;

    cfi_shadow_stack_stage dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .en_i           (en),
        .commit_valid_i (valid),
        .commit_ack_i   (ack),
        .commit_kind_i  (kind),
        .commit_pc_i    (pc),
        .commit_addr_i  (addr),
        .fault_clear_i  (fclr),
        .cfi_wait_o     (wait_o),
        .cfi_fault_o    (fault_o),
        .fault_cause_o  (cause_o),
        .fault_pc_o     (fpc_o),
        .queue_usage_o  (usage_o),
        .ss_depth_o     (ssd_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_ports();
        valid = '0;
        ack   = '0;
        kind  = '0;
        pc    = '0;
        addr  = '0;
    endtask

    task automatic drive(input int p, input logic [1:0] k, input logic [63:0] a_pc, input logic [63:0] a_addr);
        valid[p] = 1'b1;
        ack[p]   = 1'b1;
        kind[p]  = k;
        pc[p]    = a_pc;
        addr[p]  = a_addr;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic do_clear();
        fclr = 1'b1;
        tick();
        fclr = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_fault"}, 64'(fault_o), 64'd0);
        chk({tag, "_cause"}, 64'(cause_o), 64'd0);
        chk({tag, "_pc"},    fpc_o,        64'd0);
        chk({tag, "_usage"}, 64'(usage_o), 64'd0);
        chk({tag, "_ssd"},   64'(ssd_o),   64'd0);
        chk({tag, "_wait"},  64'(wait_o),  64'd0);
    endtask

    initial begin
        int pushes;
        rst  = 1'b1;
        en   = 1'b1;
        fclr = 1'b0;
        idle_ports();
        do_reset();

        // ---- reset + idle ----
        chk_all_zero("reset");
        for (int i = 0; i < 10; i++) tick();
        chk_all_zero("idle");

        // ---- two calls same cycle, then matching returns ----
        drive(0, 2'd1, 64'h8000_0100, 64'h8000_0104);
        drive(1, 2'd1, 64'h8000_0200, 64'h8000_0204);
        tick();
        idle_ports();
        chk("pair_usage", 64'(usage_o), 64'd2);
        tick();
        chk("pair_ssd1", 64'(ssd_o), 64'd1);
        tick();
        chk("pair_ssd2", 64'(ssd_o), 64'd2);
        drive(0, 2'd2, 64'h8000_0300, 64'h8000_0204);
        tick();
        idle_ports();
        tick();
        chk("ret_ssd1", 64'(ssd_o), 64'd1);
        drive(0, 2'd2, 64'h8000_0310, 64'h8000_0104);
        tick();
        idle_ports();
        tick();
        chk("ret_ssd0", 64'(ssd_o), 64'd0);
        chk("ret_nofault", 64'(fault_o), 64'd0);

        // ---- return mismatch ----
        drive(0, 2'd1, 64'h8000_0400, 64'h8000_0104);   // cycle N
        tick();
        idle_ports();
        drive(0, 2'd2, 64'h8000_0500, 64'h8000_0108);   // cycle N+1
        tick();
        idle_ports();
        chk("mm_n2_nofault", 64'(fault_o), 64'd0);      // cycle N+2
        tick();
        chk("mm_fault", 64'(fault_o), 64'd1);           // cycle N+3
        chk("mm_cause", 64'(cause_o), 64'd1);
        chk("mm_pc",    fpc_o,        64'h8000_0500);
        chk("mm_wait",  64'(wait_o),  64'd1);
        chk("mm_ssd",   64'(ssd_o),   64'd0);
        do_clear();
        chk_all_zero("mm_clear");

        // ---- address window and enable ----
        drive(0, 2'd1, 64'h0000_1000, 64'h0000_1004);
        tick();
        idle_ports();
        chk("filt_low", 64'(usage_o), 64'd0);
        drive(0, 2'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10);
        tick();
        idle_ports();
        chk("filt_hi_excl", 64'(usage_o), 64'd0);
        drive(1, 2'd3, 64'h8000_0000, 64'h10);          // kind "other"
        tick();
        idle_ports();
        chk("filt_kind3", 64'(usage_o), 64'd0);
        en = 1'b0;
        drive(0, 2'd1, 64'h8000_0000, 64'h8000_0004);
        tick();
        idle_ports();
        chk("filt_en0", 64'(usage_o), 64'd0);
        chk("filt_en0_wait", 64'(wait_o), 64'd0);
        en = 1'b1;
        drive(0, 2'd1, 64'h8000_0000, 64'h8000_0004);   // inclusive low bound
        tick();
        idle_ports();
        chk("filt_lo_incl", 64'(usage_o), 64'd1);
        tick();
        do_clear();

        // ---- throttled burst: two calls per cycle while not waiting ----
        pushes = 0;
        for (int i = 0; i < 10 && !wait_o; i++) begin
            drive(0, 2'd1, 64'h8000_1000 + 64'(8*i),     64'h9000_0000 + 64'(8*i));
            drive(1, 2'd1, 64'h8000_1004 + 64'(8*i),     64'h9000_0004 + 64'(8*i));
            tick();
            idle_ports();
            pushes += 2;
            chk($sformatf("burst_usage%0d", i), 64'(usage_o), (i == 0) ? 64'd2 : 64'(i + 2));
        end
        chk("burst_wait",   64'(wait_o),  64'd1);
        chk("burst_at7",    64'(usage_o), 64'd7);
        chk("burst_pushes", 64'(pushes),  64'd12);
        for (int i = 0; i < 20 && usage_o != 0; i++) tick();
        chk("burst_drained", 64'(usage_o), 64'd0);
        chk("burst_ssd",     64'(ssd_o),   64'd12);
        chk("burst_nofault", 64'(fault_o), 64'd0);
        // Unwind in LIFO order; any ordering error raises a mismatch.
        for (int i = 11; i >= 0; i--) begin
            drive(0, 2'd2, 64'h8000_2000, 64'h9000_0000 + 64'(4*i));
            tick();
            idle_ports();
        end
        tick();
        tick();
        chk("unwind_ssd",     64'(ssd_o),   64'd0);
        chk("unwind_nofault", 64'(fault_o), 64'd0);

        // ---- shadow stack overflow on 17th call ----
        do_clear();
        for (int i = 0; i < 17; i++) begin
            drive(0, 2'd1, 64'h8000_3000 + 64'(4*i), 64'hA000_0000 + 64'(4*i));
            tick();
            idle_ports();
        end
        tick();
        tick();
        chk("ovf_fault", 64'(fault_o), 64'd1);
        chk("ovf_cause", 64'(cause_o), 64'd3);
        chk("ovf_pc",    fpc_o,        64'h8000_3040);
        chk("ovf_ssd",   64'(ssd_o),   64'd16);

        // ---- underflow after reset ----
        do_reset();
        drive(0, 2'd2, 64'h8000_4000, 64'h8000_4444);
        tick();
        idle_ports();
        tick();
        chk("udf_fault", 64'(fault_o), 64'd1);
        chk("udf_cause", 64'(cause_o), 64'd2);
        chk("udf_pc",    fpc_o,        64'h8000_4000);

        // ---- forced overrun at usage 7 ----
        do_reset();
        for (int i = 0; i < 10 && usage_o != 7; i++) begin
            drive(0, 2'd1, 64'h8000_5000 + 64'(8*i), 64'hB000_0000 + 64'(8*i));
            drive(1, 2'd1, 64'h8000_5004 + 64'(8*i), 64'hB000_0004 + 64'(8*i));
            tick();
            idle_ports();
        end
        chk("orun_pre_usage", 64'(usage_o), 64'd7);
        drive(0, 2'd1, 64'h8000_6000, 64'hC000_0000);
        drive(1, 2'd1, 64'h8000_6004, 64'hC000_0004);
        tick();
        idle_ports();
        chk("orun_fault", 64'(fault_o), 64'd1);
        chk("orun_cause", 64'(cause_o), 64'd4);
        chk("orun_pc",    fpc_o,        64'h8000_6004);
        chk("orun_usage", 64'(usage_o), 64'd7);
        tick();
        chk("orun_halt",  64'(usage_o), 64'd7);
        do_clear();
        chk_all_zero("orun_clear");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
